// File: rtl/score_uart_rx.sv
// score_uart_rx: UART 8N1 receiver for the score link.
// One frame carries {points_second_player, points_first_player}, LSB first.
// Optional feature macro: RX_MAJORITY_VOTE_EN. When defined, every start/data/stop
// sample is the 2-of-3 majority of the synchronised line at mid-1, mid and mid+1.
// Output handshake: data_valid is a 1-cycle strobe with no ready; the scores are
// registered and hold until the next good frame, so a consumer may sample them
// in the data_valid cycle or any time afterwards.
module score_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [3:0] points_first_player,
  output logic [3:0] points_second_player,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Data/stop decisions stay at CLKS_PER_BIT-1 in both builds; with voting the
  // start decision moves one clock later, which shifts every later decision too.
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [15:0] START_LAST = 16'(CLKS_PER_BIT / 2);
`else
  localparam logic [15:0] START_LAST = 16'(CLKS_PER_BIT / 2 - 1);
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] bc_q, bc_d;
  logic [2:0]  bi_q, bi_d;
  logic [7:0]  shift_q, shift_d;
  logic        pend_q, pend_d;
  logic [3:0]  first_q, first_d;
  logic [3:0]  second_q, second_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
  logic        rxs;
  logic        sample;

  // Synchroniser shift chain; the oldest stage is the line used for decisions.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], RxD};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q, hist_d;

  // Two-deep history of rxs so the decision clock sees mid-1, mid and mid+1.
  always_comb begin
    hist_d = {hist_q[0], rxs};
    sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
  end

  // History register; idle-high after reset like the synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_q <= 2'b11;
    else      hist_q <= hist_d;
  end
`else
  assign sample = rxs;
`endif

  // Receive FSM, baud/bit counters, deshift and output load.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    bi_d     = bi_q;
    shift_d  = shift_q;
    pend_d   = 1'b0;
    first_d  = first_q;
    second_d = second_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;

    // A good stop bit was seen last clock: publish the byte now.
    if (pend_q) begin
      first_d  = shift_q[3:0];
      second_d = shift_q[7:4];
      dv_d     = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          bc_d    = 16'd0;
        end
      end
      S_START: begin
        if (bc_q == START_LAST) begin
          if (sample) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bc_d    = 16'd0;
            bi_d    = 3'd0;
          end
        end else begin
          bc_d = bc_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bc_q == BIT_LAST) begin
          shift_d = {sample, shift_q[7:1]};
          bc_d    = 16'd0;
          if (bi_q == 3'd7) state_d = S_STOP;
          else              bi_d    = bi_q + 3'd1;
        end else begin
          bc_d = bc_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bc_q == BIT_LAST) begin
          bc_d = 16'd0;
          if (sample) begin
            pend_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          bc_d = bc_q + 16'd1;
        end
      end
      S_BREAK: begin
        // A line stuck low must go high again before a new start is accepted.
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '1;
      state_q  <= S_IDLE;
      bc_q     <= 16'd0;
      bi_q     <= 3'd0;
      shift_q  <= 8'd0;
      pend_q   <= 1'b0;
      first_q  <= 4'd0;
      second_q <= 4'd0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      bc_q     <= bc_d;
      bi_q     <= bi_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      first_q  <= first_d;
      second_q <= second_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
    end
  end

  assign points_first_player  = first_q;
  assign points_second_player = second_q;
  assign data_valid           = dv_q;
  assign frame_error          = fe_q;
  assign busy                 = (state_q != S_IDLE);
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_score_uart_rx.sv
// Directed bench for score_uart_rx at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Build with +define+RX_MAJORITY_VOTE_EN to exercise the voting variant.
module tb_score_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif
  // Clocks from the start-bit falling edge (driven on a negedge) to the
  // negedge at which data_valid is first seen high.
  localparam int LAT = 9 * CPB + CPB / 2 + SYNC + 2 + VOTE;

  logic       clk;
  logic       rst;
  logic       RxD;
  logic [3:0] points_first_player;
  logic [3:0] points_second_player;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  int  vcnt = 0;
  int  ecnt = 0;
  int  both = 0;
  int  wide = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  time t_rise = 0;
  time t_fall = 0;
  logic [7:0] got_q[$];

  int v0;
  int e0;

  score_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .RxD                  (RxD),
    .points_first_player  (points_first_player),
    .points_second_player (points_second_player),
    .data_valid           (data_valid),
    .frame_error          (frame_error),
    .busy                 (busy),
    .state_dbg            (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: counts strobes, pulse widths and logs every decoded byte.
  always @(negedge clk) begin
    if (data_valid) begin
      vcnt++;
      got_q.push_back({points_second_player, points_first_player});
      if (!prev_dv) t_rise = $time;
      else          wide++;
    end
    if (frame_error) begin
      ecnt++;
      if (prev_fe) wide++;
    end
    if (data_valid && frame_error) both++;
    prev_dv = data_valid;
    prev_fe = frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: hold the line at v for n clocks (called on a negedge).
  task automatic drive_bits(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  // Driver: one 8N1 frame; gbit<8 puts a 1-clk glitch in the middle of that bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit,
                            input int stop_len);
    t_fall = $time;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive_bits(b[i], CPB / 2);
        drive_bits(~b[i], 1);
        drive_bits(b[i], CPB / 2 - 1);
      end else begin
        drive_bits(b[i], CPB);
      end
    end
    drive_bits(stop_v, stop_len);
  endtask

  initial begin
    rst = 1'b0;
    RxD = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_first",  32'(points_first_player), 32'h0);
    check("rst_second", 32'(points_second_player), 32'h0);
    check("rst_dv",     32'(data_valid), 32'h0);
    check("rst_fe",     32'(frame_error), 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_state",  32'(state_dbg), 32'h0);
    rst = 1'b1;
    drive_bits(1'b1, 5);

    // Frame 0x5A
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h5A, 1'b1, 8, CPB);
    drive_bits(1'b1, 4);
    check("f5a_count",   32'(vcnt - v0), 32'd1);
    check("f5a_first",   32'(points_first_player), 32'hA);
    check("f5a_second",  32'(points_second_player), 32'h5);
    check("f5a_noerr",   32'(ecnt - e0), 32'd0);
    check("f5a_latency", 32'(t_rise - t_fall), 32'(LAT * 10));
    check("f5a_idle",    32'(busy), 32'h0);

    // False start: 4 clocks low
    v0 = vcnt; e0 = ecnt;
    drive_bits(1'b0, 4);
    check("fs_busy_hi", 32'(busy), 32'h1);
    drive_bits(1'b1, CPB / 2 + 4);
    check("fs_busy_lo", 32'(busy), 32'h0);
    check("fs_nodv",    32'(vcnt - v0), 32'd0);
    check("fs_nofe",    32'(ecnt - e0), 32'd0);

    // Frame 0x33 with low stop bit, line held low 100 more clocks
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h33, 1'b0, 8, CPB + 100);
    check("fe_count",   32'(ecnt - e0), 32'd1);
    check("fe_nodv",    32'(vcnt - v0), 32'd0);
    check("fe_break",   32'(busy), 32'h1);
    check("fe_first",   32'(points_first_player), 32'hA);
    check("fe_second",  32'(points_second_player), 32'h5);
    drive_bits(1'b1, 2 * CPB);
    check("fe_release", 32'(busy), 32'h0);
    check("fe_once",    32'(ecnt - e0), 32'd1);
    v0 = vcnt;
    send_frame(8'h21, 1'b1, 8, CPB);
    drive_bits(1'b1, 4);
    check("f21_count",  32'(vcnt - v0), 32'd1);
    check("f21_first",  32'(points_first_player), 32'h1);
    check("f21_second", 32'(points_second_player), 32'h2);

    // Back-to-back 0x12, 0x34
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h12, 1'b1, 8, CPB);
    send_frame(8'h34, 1'b1, 8, CPB);
    drive_bits(1'b1, 4);
    check("b2b_count",  32'(vcnt - v0), 32'd2);
    check("b2b_byte0",  32'(got_q[got_q.size() - 2]), 32'h12);
    check("b2b_byte1",  32'(got_q[got_q.size() - 1]), 32'h34);
    check("b2b_first",  32'(points_first_player), 32'h4);
    check("b2b_second", 32'(points_second_player), 32'h3);
    check("b2b_noerr",  32'(ecnt - e0), 32'd0);

    // Reset during bit 4 of a 0x77 frame
    v0 = vcnt; e0 = ecnt;
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB / 2);
    rst = 1'b0;
    #1;
    check("mid_rst_first",  32'(points_first_player), 32'h0);
    check("mid_rst_second", 32'(points_second_player), 32'h0);
    check("mid_rst_dv",     32'(data_valid), 32'h0);
    check("mid_rst_fe",     32'(frame_error), 32'h0);
    check("mid_rst_busy",   32'(busy), 32'h0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_bits(1'b1, 5);
    check("mid_rst_nodv", 32'(vcnt - v0), 32'd0);
    check("mid_rst_nofe", 32'(ecnt - e0), 32'd0);
    send_frame(8'h77, 1'b1, 8, CPB);
    drive_bits(1'b1, 4);
    check("f77_count",  32'(vcnt - v0), 32'd1);
    check("f77_first",  32'(points_first_player), 32'h7);
    check("f77_second", 32'(points_second_player), 32'h7);

`ifdef RX_MAJORITY_VOTE_EN
    // Single-clock glitch in the middle of data bit 3 is voted out
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h5A, 1'b1, 3, CPB);
    drive_bits(1'b1, 4);
    check("glitch_count",  32'(vcnt - v0), 32'd1);
    check("glitch_first",  32'(points_first_player), 32'hA);
    check("glitch_second", 32'(points_second_player), 32'h5);
    check("glitch_noerr",  32'(ecnt - e0), 32'd0);
`endif

    // Strobe properties over the whole run
    check("never_both", 32'(both), 32'd0);
    check("one_clk",    32'(wide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
